uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART_tx transmitter between NUM_REQ byte-stream requesters: telemetry frame generator, fault reporter, debug dump, etc.
- Arbitration is packet-level round-robin. A winner keeps the UART until it sends a byte flagged last; other requesters cannot interleave bytes into its packet.
- Sits between the requesters and the UART_tx instance, and is the only driver of UART_tx tx_data/trmt.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT, 4096, cycles a granted requester may idle mid-packet before grant is revoked (optional feature only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_vld  input  NUM_REQ  requester i has a byte presented
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- req_last  input  NUM_REQ  presented byte is the final byte of the packet
- req_ack  output  NUM_REQ  one-cycle pulse: requester i byte launched; requester may advance next cycle
- grant  output  NUM_REQ  one-hot owner of the UART; 0 when idle
- busy  output  1  high whenever state != IDLE
- tx_data  output  8  to UART_tx
- trmt  output  1  to UART_tx, single-cycle launch pulse
- tx_done  input  1  from UART_tx; high when byte complete, cleared by UART_tx on trmt
- timeout_cnt  output  8  saturating count of revoked packets (optional feature only)

Behaviour:
- Reset values: req_ack=0, grant=0, busy=0, tx_data=8'h00, trmt=0, rr_ptr=0, timeout_cnt=0, state=IDLE. Outputs are registered.
- States: IDLE, SEND, HOLD.
- IDLE:
  - If any req_vld, pick the winner by searching upward from rr_ptr with wraparound.
  - Next cycle: grant=onehot(winner), tx_data=its byte, trmt=1, req_ack[winner]=1, captured last_flag=req_last[winner]. Go to SEND.
  - Latency from req_vld to trmt/ack is 1 cycle.
- SEND:
  - trmt and req_ack are low.
  - Wait for tx_done=1. This is never evaluated in the trmt cycle itself, so a stale tx_done from the previous byte is ignored.
  - On tx_done with last_flag=1: grant=0, rr_ptr=winner+1 mod NUM_REQ, go to IDLE.
  - On tx_done with last_flag=0: go to HOLD.
- HOLD:
  - Grant is held; req_vld from other requesters is ignored.
  - When req_vld[winner]=1: next cycle launch its byte exactly as in IDLE (trmt, ack, capture last) and go to SEND.
- req_data/req_last are sampled only in the cycle a launch decision is made. Requesters must hold vld/data/last stable until ack.
- Simultaneous requests in IDLE: round-robin order only; there is no fixed priority.
- A single-byte packet (last=1 on the first byte) is legal.
- req_vld dropping before ack: the byte is not launched and there is no error.
- NUM_REQ=1: degenerates to a pass-through with a 1-cycle launch latency.
- Reset asserted mid-packet: the FSM returns to IDLE immediately, grant is cleared, and a partially sent UART byte is abandoned (UART_tx shares rst_n).
- Throughput: at most one byte per UART byte time plus 1 cycle.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in HOLD and clears on each launch.
  - Reaching TIMEOUT cycles in HOLD revokes the grant (grant=0, rr_ptr=winner+1, go to IDLE).
  - timeout_cnt increments, saturating at 8'hFF.
- When undefined: HOLD waits indefinitely, the counter logic is absent, and timeout_cnt is tied to 0.

Test Plan:
- Reset with all req_vld=0 → trmt=0, grant=0, busy=0 for 100 cycles; no ack pulses.
- Requester 0 sends 8-byte packet AA 55 0x 0y … with last on byte 8 → exactly 8 trmt pulses with bytes in order, 8 req_ack[0] pulses, grant=001 throughout, busy falls after the 8th tx_done.
- Requesters 0, 1 and 2 request simultaneously and continuously with 2-byte packets → packet order 0, 1, 2, 0, …; no byte interleave within any packet.
- Requester 1 stalls 500 cycles mid-packet while requester 2 is requesting → requester 2 gets no trmt until requester 1 sends its last byte; requester 2 is then granted immediately.
- Reset asserted during SEND of byte 3 → grant=0 and trmt=0 asynchronously; after release a fresh request from requester 2 launches 1 cycle after req_vld.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=64, requester 0 stalls in HOLD → grant revoked at 64 cycles, timeout_cnt=1, requester 1 is granted next.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: packet-level round-robin sharing of one UART_tx among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT idle cycles mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_vld,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 trmt,
  input  logic                 tx_done,
  output logic [7:0]           timeout_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [IDX_W-1:0]   winner_q,  winner_d;
  logic [IDX_W-1:0]   rr_ptr_q,  rr_ptr_d;
  logic               last_q,    last_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic [NUM_REQ-1:0] ack_q,     ack_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               trmt_q,    trmt_d;
  logic               busy_q,    busy_d;

  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   rr_pick;
  logic               rr_any;
  logic [IDX_W-1:0]   rr_next;
  logic               launch;
  logic [IDX_W-1:0]   launch_idx;
  logic [NUM_REQ-1:0] launch_oh;
  logic [7:0]         launch_data;
  logic               launch_last;
  logic               hold_expired;

  // Search upward from rr_ptr with wraparound; the first valid requester wins.
  always_comb begin
    rr_any   = 1'b0;
    rr_pick  = rr_ptr_q;
    cand_idx = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!rr_any && req_vld[cand_idx]) begin
        rr_any  = 1'b1;
        rr_pick = cand_idx;
      end
    end
  end

  assign rr_next = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    last_d      = last_q;
    grant_d     = grant_q;
    ack_d       = '0;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    launch      = 1'b0;
    launch_idx  = winner_q;
    launch_oh   = '0;
    launch_data = 8'h00;
    launch_last = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_any) begin
          launch     = 1'b1;
          launch_idx = rr_pick;
        end
      end
      SEND: begin
        // tx_done seen during the trmt cycle is left over from the previous byte.
        if (tx_done && !trmt_q) begin
          if (last_q) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end else begin
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_vld[winner_q]) begin
          launch = 1'b1;
        end else if (hold_expired) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    for (int k = 0; k < NUM_REQ; k++) begin
      if (launch_idx == IDX_W'(k)) begin
        launch_oh[k] = 1'b1;
        launch_data  = req_data[8*k +: 8];
        launch_last  = req_last[k];
      end
    end

    if (launch) begin
      state_d   = SEND;
      winner_d  = launch_idx;
      grant_d   = launch_oh;
      ack_d     = launch_oh;
      tx_data_d = launch_data;
      trmt_d    = 1'b1;
      last_d    = launch_last;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      winner_q  <= '0;
      rr_ptr_q  <= '0;
      last_q    <= 1'b0;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_data_q <= 8'h00;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_ptr_q  <= rr_ptr_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int HC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]      tmo_cnt_q,  tmo_cnt_d;

  // The TIMEOUT-th consecutive idle HOLD cycle revokes the grant.
  assign hold_expired = (hold_cnt_q == HC_W'(TIMEOUT - 1));

  always_comb begin
    hold_cnt_d = '0;
    tmo_cnt_d  = tmo_cnt_q;
    if (state_q == HOLD && !req_vld[winner_q]) begin
      if (hold_expired) begin
        if (tmo_cnt_q != 8'hFF) begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      tmo_cnt_q  <= 8'h00;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign timeout_cnt = tmo_cnt_q;
`else
  // Without the feature HOLD waits indefinitely; TIMEOUT has no effect.
  assign hold_expired = (TIMEOUT < 0);
  assign timeout_cnt  = 8'h00;
`endif

  assign req_ack = ack_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign tx_data = tx_data_q;
  assign trmt    = trmt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: random and directed requester traffic checked against a packet-level model.
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_vld, req_last, req_ack, grant;
  logic [8*N-1:0] req_data;
  logic           busy, trmt, tx_done;
  logic [7:0]     tx_data, timeout_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .busy(busy),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done), .timeout_cnt(timeout_cnt)
  );

  // requester side: each holds a queue of pending bytes
  logic [7:0] bq [N][$];
  int stall [N];
  int launches [N];
  int trmt_seen [N];
  int acks_seen [N];
  bit refill;
  int vld_pct, min_len, max_len;

  // packet-level reference model
  int m_owner, m_rr, m_hold, m_tcnt;
  bit m_inflight, m_last, m_just;
  bit exp_trmt;
  logic [7:0] exp_data;
  logic [N-1:0] exp_ack, exp_grant;

  // UART_tx behaviour
  bit u_pend;
  int u_cnt;

  int base_t, base_a, c, tr2, l0, l1, l2, mx, mn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_hold = 0; m_tcnt = 0;
    m_inflight = 0; m_last = 0; m_just = 0;
  endtask

  task automatic add_pkt(input int i, input int len);
    for (int b = 0; b < len; b++) bq[i].push_back(8'($urandom));
  endtask

  function automatic bit pending();
    bit p;
    p = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (bq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() > 0) begin
        req_data[8*i +: 8] = bq[i][0];
        req_last[i] = (bq[i].size() == 1);
        req_vld[i]  = (stall[i] == 0) && ($urandom_range(99) < vld_pct);
      end else begin
        req_vld[i]  = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // One arbitration decision per clock, evaluated on the inputs present at the edge.
  task automatic model(input logic [N-1:0] sv, input logic [N-1:0] sl,
                       input logic [8*N-1:0] sd, input logic sdone);
    bit go;
    int w;
    go = 1'b0; w = 0;
    exp_ack = '0; exp_trmt = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (!go && sv[(m_rr + k) % N]) begin go = 1'b1; w = (m_rr + k) % N; end
      end
    end else if (m_inflight) begin
      if (sdone && !m_just) begin
        m_inflight = 1'b0;
        m_hold = 0;
        if (m_last) begin m_rr = (m_owner + 1) % N; m_owner = -1; end
      end
    end else if (sv[m_owner]) begin
      go = 1'b1; w = m_owner;
    end
`ifdef UART_ARB_TIMEOUT_EN
    else begin
      m_hold++;
      if (m_hold == TMO) begin
        m_rr = (m_owner + 1) % N; m_owner = -1;
        if (m_tcnt < 255) m_tcnt++;
      end
    end
`endif
    m_just = go;
    if (go) begin
      m_owner = w; m_inflight = 1'b1; m_last = sl[w];
      exp_trmt = 1'b1; exp_data = sd[8*w +: 8]; exp_ack[w] = 1'b1;
    end
    exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endtask

  task automatic step();
    logic [N-1:0] sv, sl;
    logic [8*N-1:0] sd;
    logic sdone;
    drive_reqs();
    sv = req_vld; sl = req_last; sd = req_data; sdone = tx_done;
    @(posedge clk); #1;
    model(sv, sl, sd, sdone);
    chk("trmt", 32'(trmt), 32'(exp_trmt));
    chk("req_ack", 32'(req_ack), 32'(exp_ack));
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(m_tcnt));
    if (exp_trmt) chk("tx_data", 32'(tx_data), 32'(exp_data));
    for (int i = 0; i < N; i++) begin
      if (trmt && grant[i]) trmt_seen[i]++;
      if (req_ack[i]) acks_seen[i]++;
      if (exp_ack[i] && bq[i].size() > 0) begin
        bq[i].delete(0);
        launches[i]++;
        if (bq[i].size() == 0 && refill) add_pkt(i, $urandom_range(max_len, min_len));
      end
      if (stall[i] > 0) stall[i]--;
    end
    // UART clears tx_done on the edge that samples trmt, then finishes after a few cycles.
    if (u_pend) begin
      tx_done = 1'b0; u_cnt = $urandom_range(6, 2); u_pend = 1'b0;
    end else if (!tx_done) begin
      u_cnt--;
      if (u_cnt <= 0) tx_done = 1'b1;
    end
    if (exp_trmt) u_pend = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    refill = 1'b0; vld_pct = 100;
    while (pending() && n < bound) begin step(); n++; end
    chk("drain_done", 32'(pending()), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '0; req_last = '0; req_data = '0; tx_done = 1'b1;
    model_reset();
    refill = 1'b0; vld_pct = 100; min_len = 1; max_len = 4; u_pend = 1'b0; u_cnt = 0;
    for (int i = 0; i < N; i++) begin
      stall[i] = 0; launches[i] = 0; trmt_seen[i] = 0; acks_seen[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_trmt", 32'(trmt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ack", 32'(req_ack), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'(0));
    rst_n = 1'b1;

    // idle for 100 cycles
    repeat (100) step();
    chk("idle_acks", 32'(acks_seen[0] + acks_seen[1] + acks_seen[2]), 32'(0));

    // requester 0 sends one 8-byte packet
    base_t = trmt_seen[0]; base_a = acks_seen[0];
    bq[0].push_back(8'hAA); bq[0].push_back(8'h55);
    for (int b = 1; b <= 6; b++) bq[0].push_back(8'(b));
    drain(400);
    chk("pkt8_trmt", 32'(trmt_seen[0] - base_t), 32'(8));
    chk("pkt8_ack", 32'(acks_seen[0] - base_a), 32'(8));

    // all three continuously with 2-byte packets
    l0 = launches[0]; l1 = launches[1]; l2 = launches[2];
    refill = 1'b1; min_len = 2; max_len = 2; vld_pct = 100;
    for (int i = 0; i < N; i++) add_pkt(i, 2);
    repeat (300) step();
    drain(500);
    l0 = launches[0] - l0; l1 = launches[1] - l1; l2 = launches[2] - l2;
    mx = (l0 > l1) ? l0 : l1; mx = (mx > l2) ? mx : l2;
    mn = (l0 < l1) ? l0 : l1; mn = (mn < l2) ? mn : l2;
    chk("rr_fair", 32'(mx - mn <= 2 && mn > 0), 32'(1));

    // random lengths with vld dropping in and out
    refill = 1'b1; min_len = 1; max_len = 4; vld_pct = 70;
    for (int i = 0; i < N; i++) add_pkt(i, $urandom_range(4, 1));
    repeat (3000) step();
    drain(1000);

    // requester 1 stalls 500 cycles mid-packet while requester 2 waits
    vld_pct = 100;
    add_pkt(1, 2);
    c = 0; l1 = launches[1];
    while (launches[1] == l1 && c < 50) begin step(); c++; end
    chk("stall_first_byte", 32'(launches[1] - l1), 32'(1));
    stall[1] = 500;
    add_pkt(2, 1);
    tr2 = trmt_seen[2]; l2 = launches[2];
    repeat (490) step();
    chk("stall_no_r2", 32'(trmt_seen[2] - tr2), 32'(0));
    drain(2000);
    chk("stall_r2_after", 32'(launches[2] - l2), 32'(1));

`ifdef UART_ARB_TIMEOUT_EN
    // requester 0 stalls in HOLD until the grant is revoked
    add_pkt(0, 2);
    c = 0; l0 = launches[0];
    while (launches[0] == l0 && c < 50) begin step(); c++; end
    stall[0] = 200;
    add_pkt(1, 1);
    l1 = launches[1];
    repeat (150) step();
    chk("tmo_count", 32'(timeout_cnt), 32'(1));
    chk("tmo_r1_granted", 32'(launches[1] - l1), 32'(1));
    drain(1000);
`endif

    // asynchronous reset during SEND of byte 3
    add_pkt(0, 5);
    c = 0; l0 = launches[0];
    while (launches[0] - l0 < 3 && c < 200) begin step(); c++; end
    #2; rst_n = 1'b0; #1;
    chk("arst_grant", 32'(grant), 32'(0));
    chk("arst_trmt", 32'(trmt), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    for (int i = 0; i < N; i++) begin bq[i].delete(); stall[i] = 0; end
    req_vld = '0; tx_done = 1'b1; u_pend = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    bq[2].push_back(8'h3C);
    step();
    chk("post_rst_launch", 32'({trmt, grant}), 32'({1'b1, 3'b100}));
    chk("post_rst_data", 32'(tx_data), 32'(8'h3C));
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
